ram_burst_master: RTL and testbench

Initiator-side controller for the 16x16 single-port RAM (cs active-high; rw=1 read, rw=0 write; read data registered one clock after the issue edge). Accepts single or burst read/write requests from the processor datapath. Sequences the RAM control pins one beat per clock and returns registered read data with a valid strobe. Sits between the RISC control unit and the data RAM.

---
 rtl/ram_burst_master.sv | 190 +++++++++++++++++++
 tb/tb_ram_burst_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : ram_burst_master
// Brief   : Burst read/write sequencer for a single-port RAM, one beat per
//           clock. Optional write read-back verify: RAM_MASTER_VERIFY_EN.
// Rev     : 1.0
// ============================================================================
module ram_burst_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [3:0]        burst_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4,
    S_VRD    = 3'd5,
    S_VDRAIN = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len;
  logic [3:0]        r_cnt;
  logic              r_rd_pend;
  logic              w_last;

  assign w_last = (r_cnt == r_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // RAM pins are decoded from state so reset drops ram_cs without a clock.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    done      = 1'b0;
    wr_ack    = 1'b0;
    ram_cs    = 1'b0;
    ram_rw    = 1'b1;
    ram_addr  = '0;
    ram_wdata = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) w_next = we ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        ram_cs    = 1'b1;
        ram_rw    = 1'b0;
        ram_addr  = r_addr;
        ram_wdata = wdata;
        wr_ack    = 1'b1;
`ifdef RAM_MASTER_VERIFY_EN
        if (w_last) w_next = S_VRD;
`else
        if (w_last) w_next = S_DONE;
`endif
      end
      S_READ: begin
        ram_cs   = 1'b1;
        ram_addr = r_addr;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
`ifdef RAM_MASTER_VERIFY_EN
      S_VRD: begin
        ram_cs   = 1'b1;
        ram_addr = r_addr;
        if (w_last) w_next = S_VDRAIN;
      end
      S_VDRAIN: w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_start <= start_addr;
            r_addr  <= start_addr;
            r_len   <= burst_len;
            r_cnt   <= '0;
          end
        end
        S_WRITE: begin
          // Rewind so a verify pass re-reads the same address window.
          if (w_last) begin
            r_addr <= r_start;
            r_cnt  <= '0;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        S_READ, S_VRD: begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend   <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      r_rd_pend   <= (r_state == S_READ);
      rdata_valid <= r_rd_pend;
      if (r_rd_pend) rdata <= ram_rdata;
    end
  end

`ifdef RAM_MASTER_VERIFY_EN
  logic [DATA_W-1:0] r_shadow [2**ADDR_W];
  logic              r_v_pend;
  logic [ADDR_W-1:0] r_v_addr;
  logic              r_verr;
  logic [ADDR_W-1:0] r_eaddr;

  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) r_shadow[r_addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v_pend <= 1'b0;
      r_v_addr <= '0;
      r_verr   <= 1'b0;
      r_eaddr  <= '0;
    end else begin
      r_v_pend <= (r_state == S_VRD);
      r_v_addr <= r_addr;
      if (r_v_pend && !r_verr && (ram_rdata != r_shadow[r_v_addr])) begin
        r_verr  <= 1'b1;
        r_eaddr <= r_v_addr;
      end
    end
  end

  assign verify_err = r_verr;
  assign err_addr   = r_eaddr;
`else
  assign verify_err = 1'b0;
  assign err_addr   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_burst_master
// Brief   : Random and directed bursts checked every cycle against a
//           transaction-level timeline model; RAM_MASTER_VERIFY_EN aware.
// Rev     : 1.0
// ============================================================================
module tb_ram_burst_master;
  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  start_addr = '0;
  logic [3:0]  burst_len = '0;
  logic [15:0] wdata = '0;
  logic        wr_ack, rdata_valid, busy, done, verify_err, ram_cs, ram_rw;
  logic [15:0] rdata, ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [3:0]  err_addr, ram_addr;

  ram_burst_master #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .start_addr(start_addr),
    .burst_len(burst_len), .wdata(wdata), .wr_ack(wr_ack), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .verify_err(verify_err), .err_addr(err_addr), .ram_cs(ram_cs),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d: bound expired", nm, cyc);
  endtask

  // Environment RAM: registered read, optional corruption of address 5 reads.
  logic [15:0] mem [16];
  logic        init_req = 1'b0;
  logic        corrupt = 1'b0;

  function automatic logic [15:0] init_val(input int i);
    if (i < 4)   return 16'(i + 1);
    if (i == 14) return 16'h0094;
    if (i == 15) return 16'h0105;
    return 16'(i * 16'h1111);
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (ram_cs) begin
      if (ram_rw) ram_rdata <= (corrupt && ram_addr == 4'd5) ? (mem[ram_addr] ^ 16'h00FF) : mem[ram_addr];
      else        mem[ram_addr] <= ram_wdata;
    end
  end

  // Timeline model: expected pin values per cycle index, plus golden memory.
  bit          e_busy [NC];
  bit          e_cs   [NC];
  bit          e_rw   [NC];
  bit          e_ack  [NC];
  bit          e_done [NC];
  bit          e_rv   [NC];
  bit          e_vdc  [NC];
  bit          e_vset [NC];
  logic [3:0]  e_addr [NC];
  logic [15:0] e_wd   [NC];
  logic [15:0] e_rd   [NC];
  logic [15:0] gm     [16];
  logic [15:0] txw    [16];
  bit          mv = 1'b0;
  logic [3:0]  mva = '0;

  task automatic clear_model(input int from);
    for (int t = from; t < from + 48 && t < NC; t++) begin
      e_busy[t] = 0; e_cs[t] = 0; e_rw[t] = 0; e_ack[t] = 0; e_done[t] = 0;
      e_rv[t] = 0; e_vdc[t] = 0; e_vset[t] = 0;
    end
  endtask

  task automatic model_fill(input int a, input bit w, input logic [3:0] sa, input int len);
    int dn;
    for (int i = 0; i <= len; i++) begin
      e_busy[a+1+i] = 1; e_cs[a+1+i] = 1; e_rw[a+1+i] = !w;
      e_addr[a+1+i] = 4'(sa + i); e_ack[a+1+i] = w; e_wd[a+1+i] = txw[i];
      if (!w) begin
        e_rv[a+3+i] = 1;
        e_rd[a+3+i] = gm[4'(sa + i)];
      end
    end
    if (w) begin
      for (int i = 0; i <= len; i++) gm[4'(sa + i)] = txw[i];
`ifdef RAM_MASTER_VERIFY_EN
      for (int i = 0; i <= len; i++) begin
        e_busy[a+len+2+i] = 1; e_cs[a+len+2+i] = 1; e_rw[a+len+2+i] = 1;
        e_addr[a+len+2+i] = 4'(sa + i);
      end
      e_busy[a+2*len+3] = 1;
      for (int t = a + len + 2; t <= a + 2*len + 3; t++) e_vdc[t] = 1;
      for (int i = 0; i <= len; i++)
        if (corrupt && 4'(sa + i) == 4'd5) e_vset[a+2*len+4] = 1;
      dn = a + 2*len + 4;
`else
      dn = a + len + 2;
`endif
    end else begin
      e_busy[a+len+2] = 1;
      dn = a + len + 3;
    end
    e_busy[dn] = 1;
    e_done[dn] = 1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mv  = 1'b0;
      mva = '0;
    end
    if (cyc < NC) begin
      if (e_vset[cyc] && !mv) begin
        mv  = 1'b1;
        mva = 4'd5;
      end
      check("busy", busy, e_busy[cyc]);
      check("ram_cs", ram_cs, e_cs[cyc]);
      check("ram_rw", ram_rw, e_cs[cyc] ? e_rw[cyc] : 1'b1);
      check("wr_ack", wr_ack, e_ack[cyc]);
      check("done", done, e_done[cyc]);
      check("rdata_valid", rdata_valid, e_rv[cyc]);
      if (e_cs[cyc]) check("ram_addr", ram_addr, e_addr[cyc]);
      if (e_cs[cyc] && !e_rw[cyc]) check("ram_wdata", ram_wdata, e_wd[cyc]);
      if (e_rv[cyc]) check("rdata", rdata, e_rd[cyc]);
      if (!e_vdc[cyc]) begin
        check("verify_err", verify_err, mv);
        check("err_addr", err_addr, mva);
      end
    end
  end

  // Observation log for the directed literal checks.
  logic [3:0]  addr_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] wd_q [$];
  int n_ack = 0;
  int n_done = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (ram_cs) addr_q.push_back(ram_addr);
    if (rdata_valid) rd_q.push_back(rdata);
    if (wr_ack) begin
      wd_q.push_back(ram_wdata);
      n_ack++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic ram_init();
    for (int i = 0; i < 16; i++) gm[i] = init_val(i);
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  task automatic do_txn(input bit w, input logic [3:0] sa, input logic [3:0] len,
                        input int fixw, input bit pulse, output int a);
    int k, wd;
    for (int i = 0; i < 16; i++) txw[i] = 16'($urandom);
    if (fixw >= 0) txw[0] = 16'(fixw);
    req = 1'b1; we = w; start_addr = sa; burst_len = len; wdata = txw[0];
    a = cyc;
    model_fill(a, w, sa, int'(len));
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); start_addr = 4'($urandom); burst_len = 4'($urandom);
    if (w) begin
      k = 0; wd = 0;
      while (k <= int'(len) && wd < 8) begin
        @(negedge clk);
        if (wr_ack) begin
          @(posedge clk); #1;
          k++;
          if (k <= int'(len)) wdata = txw[k];
        end else begin
          wd++;
        end
        req = pulse && (k == 2);
      end
      req = 1'b0;
      if (wd >= 8) fail_now("wr_ack_wait");
    end
    wd = 0;
    @(negedge clk);
    while (!done && wd < 60) begin
      @(negedge clk);
      wd++;
    end
    if (!done) fail_now("done_wait");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, i0, nd0, na0;
    logic [3:0]  ea [4];
    logic [15:0] er [4];

    #1 rst = 1'b0;
    #1;
    check("rst_ram_cs", ram_cs, 1'b0);
    check("rst_ram_rw", ram_rw, 1'b1);
    check("rst_ram_addr", ram_addr, 4'd0);
    check("rst_ram_wdata", ram_wdata, 16'd0);
    check("rst_rdata", rdata, 16'd0);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_verify_err", verify_err, 1'b0);
    check("rst_err_addr", err_addr, 4'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    ram_init();

    // Incrementing read from 0 after RAM init.
    i0 = rd_q.size();
    do_txn(1'b0, 4'd0, 4'd3, -1, 1'b0, a);
    check("rd4_done_latency", done_cyc - a, 6);
    er[0] = 16'h0001; er[1] = 16'h0002; er[2] = 16'h0003; er[3] = 16'h0004;
    if (rd_q.size() < i0 + 4) fail_now("rd4_count");
    else for (int k = 0; k < 4; k++) check("rd4_data", rd_q[i0+k], er[k]);

    // Address wrap 14,15,0,1.
    i0 = rd_q.size();
    nd0 = addr_q.size();
    do_txn(1'b0, 4'd14, 4'd3, -1, 1'b0, a);
    ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0; ea[3] = 4'd1;
    er[0] = 16'h0094; er[1] = 16'h0105; er[2] = 16'h0001; er[3] = 16'h0002;
    if (rd_q.size() < i0 + 4 || addr_q.size() < nd0 + 4) fail_now("wrap_count");
    else for (int k = 0; k < 4; k++) begin
      check("wrap_addr", addr_q[nd0+k], ea[k]);
      check("wrap_data", rd_q[i0+k], er[k]);
    end

    // Single write then readback.
    do_txn(1'b1, 4'd3, 4'd0, 16'hBEEF, 1'b0, a);
    check("sw_addr", addr_q[$], 4'd3);
    check("sw_wdata", wd_q[$], 16'hBEEF);
`ifdef RAM_MASTER_VERIFY_EN
    check("sw_done_latency", done_cyc - a, 4);
`else
    check("sw_done_latency", done_cyc - a, 2);
`endif
    do_txn(1'b0, 4'd3, 4'd0, -1, 1'b0, a);
    check("sw_readback", rd_q[$], 16'hBEEF);

    // Asynchronous reset in the middle of an 8-beat read.
    for (int i = 0; i < 16; i++) txw[i] = '0;
    req = 1'b1; we = 1'b0; start_addr = 4'd2; burst_len = 4'd7;
    a = cyc;
    model_fill(a, 1'b0, 4'd2, 7);
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    nd0 = n_done;
    clear_model(cyc);
    #1 rst = 1'b0;
    #1;
    check("midrst_ram_cs", ram_cs, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdata_valid", rdata_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", n_done - nd0, 0);
    do_txn(1'b0, 4'd0, 4'd1, -1, 1'b0, a);

    // req pulsed mid-write must be ignored.
    na0 = n_ack;
    nd0 = n_done;
    do_txn(1'b1, 4'd9, 4'd7, -1, 1'b1, a);
    repeat (4) @(posedge clk);
    #1;
    check("pulse_acks", n_ack - na0, 8);
    check("pulse_dones", n_done - nd0, 1);

    // Randomized traffic with gaps of 0..3 idle cycles.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), 4'($urandom), 4'($urandom), -1, 1'b0, a);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Write of 4 beats from 4 with reads of address 5 corrupted.
    corrupt = 1'b1;
    do_txn(1'b1, 4'd4, 4'd3, -1, 1'b0, a);
    corrupt = 1'b0;
`ifdef RAM_MASTER_VERIFY_EN
    check("vfy_err", verify_err, 1'b1);
    check("vfy_err_addr", err_addr, 4'd5);
    check("vfy_done_latency", done_cyc - a, 10);
`else
    check("vfy_err", verify_err, 1'b0);
    check("vfy_err_addr", err_addr, 4'd0);
    check("vfy_done_latency", done_cyc - a, 5);
`endif
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
